gpr_wb_arbiter: RTL and testbench

// - Shares the single GPR write port (wen/waddr/wdata) between two writeback requesters: EXU (req0) and LSU (req1).
// - Round-robin arbitration with valid/ready handshakes and a registered output stage that drives the GPR write port.
// - Filters x0 writes and counts retired writebacks.
// - Sits between the EXU/LSU writeback paths and the GPR instance in the NPC core.

---
 rtl/gpr_pkg.sv | 14 +
 rtl/gpr_wb_arbiter_rr_arb2.sv | 39 +++
 rtl/gpr_wb_arbiter.sv | 107 ++++++++++
 tb/tb_gpr_wb_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - shared GPR writeback types and constants
package gpr_pkg;

  localparam int unsigned GPR_ADDR_W = 5;
  localparam int unsigned GPR_DATA_W = 32;

  localparam logic [GPR_ADDR_W-1:0] GPR_X0 = 5'd0;

  typedef enum logic {
    REQ_EXU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage

// File: rtl/gpr_wb_arbiter_rr_arb2.sv
// rtl/gpr_wb_arbiter_rr_arb2.sv - two-way round-robin arbiter with last-grant memory
module rr_arb2
  import gpr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e last_q;
  req_id_e last_d;

  // Reset leaves last = LSU so that a tie after reset goes to EXU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_LSU;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_q == REQ_EXU) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
    if (gnt[0]) last_d = REQ_EXU;
    if (gnt[1]) last_d = REQ_LSU;
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// rtl/gpr_wb_arbiter.sv - EXU/LSU writeback arbiter feeding the GPR write port
// Optional write-to-read bypass on the decode read ports: GPR_WB_BYPASS_EN.
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = GPR_ADDR_W,
  parameter int unsigned DATA_WIDTH = GPR_DATA_W,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  gpr_wen,
  output logic [ADDR_WIDTH-1:0] gpr_waddr,
  output logic [DATA_WIDTH-1:0] gpr_wdata,
  output logic [CNT_WIDTH-1:0]  wb_cnt,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  input  logic [DATA_WIDTH-1:0] gpr_rdata1,
  input  logic [DATA_WIDTH-1:0] gpr_rdata2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2
);

  localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(GPR_X0);

  logic [1:0]            gnt;
  logic                  granted;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  wen_q,   wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst),
    .en    (!stall),
    .req   ({req1_valid, req0_valid}),
    .gnt   (gnt)
  );

  // Ready is masked by reset combinationally so nothing is accepted while held.
  assign req0_ready = gnt[0] & rst;
  assign req1_ready = gnt[1] & rst;

  assign granted  = |gnt;
  assign sel_addr = gnt[1] ? req1_addr : req0_addr;
  assign sel_data = gnt[1] ? req1_data : req0_data;

  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (granted) begin
      wen_d   = (sel_addr != X0);
      waddr_d = sel_addr;
      wdata_d = sel_data;
    end
    cnt_d = cnt_q + CNT_WIDTH'(wen_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gpr_wen   = wen_q;
  assign gpr_waddr = waddr_q;
  assign gpr_wdata = wdata_q;
  assign wb_cnt    = cnt_q;

`ifdef GPR_WB_BYPASS_EN
  // The GPR array only shows the slot's write one cycle later; forward it meanwhile.
  always_comb begin
    rdata1 = gpr_rdata1;
    rdata2 = gpr_rdata2;
    if (wen_q && (waddr_q == raddr1) && (raddr1 != X0)) rdata1 = wdata_q;
    if (wen_q && (waddr_q == raddr2) && (raddr2 != X0)) rdata2 = wdata_q;
  end
`else
  logic unused_raddr;
  assign unused_raddr = ^{raddr1, raddr2};
  assign rdata1 = gpr_rdata1;
  assign rdata2 = gpr_rdata2;
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb/tb_gpr_wb_arbiter.sv - self-checking bench for gpr_wb_arbiter
module tb_gpr_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic [31:0] wb_cnt;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] gpr_rdata1, gpr_rdata2;
  logic [31:0] rdata1, rdata2;

  typedef struct packed {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  logic        m_last;
  logic        m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_cnt;
  logic [31:0] d0_ctr, d1_ctr;

  always #5 clk = ~clk;

  gpr_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst_n),
    .stall      (stall),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .gpr_wen    (gpr_wen),
    .gpr_waddr  (gpr_waddr),
    .gpr_wdata  (gpr_wdata),
    .wb_cnt     (wb_cnt),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .gpr_rdata1 (gpr_rdata1),
    .gpr_rdata2 (gpr_rdata2),
    .rdata1     (rdata1),
    .rdata2     (rdata2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1'b1;
    m_wen  = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_cnt  = '0;
    sb.delete();
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".wen"},   {63'd0, gpr_wen},   {63'd0, e.wen});
    check({tag, ".waddr"}, {59'd0, gpr_waddr}, {59'd0, e.addr});
    check({tag, ".wdata"}, {32'd0, gpr_wdata}, {32'd0, e.data});
    check({tag, ".cnt"},   {32'd0, wb_cnt},    {32'd0, e.cnt});
  endtask

  // One clock: drive, check ready against the model, queue the expected slot, step, compare.
  task automatic cycle(input string tag,
                       input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic st, output logic g0, output logic g1);
    exp_t e;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    stall = st;
    #1;
    g0 = rst_n && !st && v0 && (!v1 || m_last);
    g1 = rst_n && !st && v1 && (!v0 || !m_last);
    check({tag, ".ready0"}, {63'd0, req0_ready}, {63'd0, g0});
    check({tag, ".ready1"}, {63'd0, req1_ready}, {63'd0, g1});
    if (g0 || g1) begin
      m_addr = g1 ? a1 : a0;
      m_data = g1 ? d1 : d0;
      m_wen  = (m_addr != 5'd0);
      m_last = g1;
      if (m_wen) m_cnt = m_cnt + 1;
    end else begin
      m_wen = 1'b0;
    end
    sb.push_back('{wen: m_wen, addr: m_addr, data: m_data, cnt: m_cnt});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check_outputs(tag, e);
    end
  endtask

  initial begin
    logic g0, g1;
    exp_t z;
    rst_n = 1'b0; stall = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    raddr1 = '0; raddr2 = '0;
    gpr_rdata1 = 32'hDEAD_0001; gpr_rdata2 = 32'hBEEF_0002;
    z = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", z);
    check("reset.ready0", {63'd0, req0_ready}, 64'd0);
    rst_n = 1'b1;

    // Lone EXU request: granted immediately, written next cycle.
    cycle("single", 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0, 1'b0, g0, g1);
    check("single.grant0", {63'd0, g0}, 64'd1);
    check("single.cnt_abs", {32'd0, wb_cnt}, 64'd1);

    // x0 write from LSU: accepted, no write, no count.
    cycle("x0", 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFF, 1'b0, g0, g1);
    check("x0.wen_abs", {63'd0, gpr_wen}, 64'd0);
    check("x0.cnt_abs", {32'd0, wb_cnt}, 64'd1);

    // Both valid; each requester drops after its grant.
    cycle("both_a", 1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 1'b0, g0, g1);
    check("both_a.first_req0", {62'd0, g1, g0}, 64'b01);
    check("both_a.waddr_abs", {59'd0, gpr_waddr}, 64'd3);
    cycle("both_b", 1'b0, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 1'b0, g0, g1);
    check("both_b.then_req1", {62'd0, g1, g0}, 64'b10);
    check("both_b.wdata_abs", {32'd0, gpr_wdata}, 64'hB);
    cycle("both_c", 1'b0, 5'd3, 32'hA, 1'b0, 5'd4, 32'hB, 1'b0, g0, g1);

    // Held contention: strict alternation, new data after each grant.
    d0_ctr = 32'h100; d1_ctr = 32'h200;
    for (int i = 0; i < 6; i++) begin
      cycle("alt", 1'b1, 5'd10, d0_ctr, 1'b1, 5'd11, d1_ctr, 1'b0, g0, g1);
      check("alt.pattern", {62'd0, g1, g0}, (i % 2 == 0) ? 64'b01 : 64'b10);
      if (g0) d0_ctr++;
      if (g1) d1_ctr++;
    end

    // Stall with both valid for two cycles, then resume.
    cycle("stall1", 1'b1, 5'd12, 32'h300, 1'b1, 5'd13, 32'h400, 1'b1, g0, g1);
    cycle("stall2", 1'b1, 5'd12, 32'h300, 1'b1, 5'd13, 32'h400, 1'b1, g0, g1);
    check("stall2.wen_abs", {63'd0, gpr_wen}, 64'd0);
    cycle("resume", 1'b1, 5'd12, 32'h300, 1'b1, 5'd13, 32'h400, 1'b0, g0, g1);
    check("resume.grant", {62'd0, g1, g0}, 64'b01);

    // Write (7,0x55) in flight exercises the decode bypass.
    cycle("bypw", 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h55, 1'b0, g0, g1);
    raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
`ifdef GPR_WB_BYPASS_EN
    check("byp.rdata1_hit", {32'd0, rdata1}, 64'h55);
    check("byp.rdata2_hit", {32'd0, rdata2}, 64'h55);
`else
    check("byp.rdata1_pass", {32'd0, rdata1}, 64'hDEAD_0001);
    check("byp.rdata2_pass", {32'd0, rdata2}, 64'hBEEF_0002);
`endif
    raddr1 = 5'd0; raddr2 = 5'd9;
    #1;
    check("byp.rdata1_x0", {32'd0, rdata1}, 64'hDEAD_0001);
    check("byp.rdata2_miss", {32'd0, rdata2}, 64'hBEEF_0002);

    // Grant, then async reset before the edge: in-flight write dropped.
    cycle("pre_rst", 1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'h0, 1'b0, g0, g1);
    check("pre_rst.wen_abs", {63'd0, gpr_wen}, 64'd1);
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h66;
    #1;
    check("mid.ready1", {63'd0, req1_ready}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_outputs("mid_rst", z);
    check("mid_rst.ready0", {63'd0, req0_ready}, 64'd0);
    check("mid_rst.ready1", {63'd0, req1_ready}, 64'd0);
    @(posedge clk);
    #1;
    check_outputs("mid_rst_edge", z);
    model_reset();
    rst_n = 1'b1;
    cycle("post_rst", 1'b1, 5'd9, 32'h99, 1'b1, 5'd6, 32'h66, 1'b0, g0, g1);
    check("post_rst.req0_first", {62'd0, g1, g0}, 64'b01);
    cycle("idle", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, g0, g1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
